mips_cpu_bus_sequencer: RTL and testbench

- Multi-cycle FETCH/EXEC sequencer that owns the CPU's single Avalon-style memory port.
- Drives the datapath's `state` and `valid_data` inputs.
- Arbitrates the bus between instruction fetch and load/store accesses, stalls on `waitrequest` and on a busy multi-cycle ALU op, and buffers load data so the datapath can write it back during the following FETCH.
- Sits between the top-level bus pins, the PC register, the decoder/controller and the datapath.

---
 rtl/mips_cpu_pkg.sv | 33 +++
 rtl/mips_cpu_bus_timeout.sv | 30 +++
 rtl/mips_cpu_bus_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_mips_cpu_bus_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, byte-lane constants and the
// load/store opcode table used by the decoder that produces is_load/is_store.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  function automatic logic op_is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LWL) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWR);
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_cpu_bus_timeout.sv
// Saturating count of consecutive stalled bus cycles for the access in flight.
module mips_cpu_bus_timeout #(
  parameter int LIMIT = 1024,
  parameter int CNT_W = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic incr,
  output logic limit_reached
);

  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count;

  // Fires on the increment that brings the count to LIMIT so the owner can react on that edge.
  assign limit_reached = incr && (count >= (LIMIT_V - CNT_W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && (count != LIMIT_V)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_cpu_bus_sequencer.sv
// FETCH/EXEC sequencer owning the CPU's single memory port; buffers load data so the
// datapath writes it back during the first cycle of the following FETCH.
module mips_cpu_bus_sequencer
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR  = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 1024,
  parameter int          CNT_W      = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        alu_busy,
  input  logic [31:0] dp_readaddr,
  input  logic [31:0] dp_writeaddr,
  input  logic [31:0] dp_writedata,
  input  logic [3:0]  dp_byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  output logic        state,
  output logic        valid_data,
  output logic [31:0] dp_readdata,
  output logic [31:0] instr_word,
  output logic        pc_en,
  output logic        active,
  output logic        bus_error,
  output seq_state_t  seq_state
);

  seq_state_t  state_q, state_d;
  logic        read_q, read_d, write_q, write_d;
  logic [31:0] address_q, address_d, writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic [31:0] instr_word_q, instr_word_d, load_buf_q, load_buf_d;
  logic        load_pend_q, load_pend_d;
  logic        acc_done_q, acc_done_d;
  logic        bus_error_q, bus_error_d;
  logic        advance;
  logic        strobe, accepted, stalled, timeout;

  // Handshake: an access is accepted on a rising edge where read or write is high and
  // waitrequest is low; address, byteenable and writedata are held unchanged until then.
  assign strobe   = read_q | write_q;
  assign accepted = strobe & ~waitrequest;
  assign stalled  = strobe & waitrequest;

  mips_cpu_bus_timeout #(
    .LIMIT (WAIT_LIMIT),
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk           (clk),
    .reset         (reset),
    .clear         (accepted),
    .incr          (stalled),
    .limit_reached (timeout)
  );

  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    instr_word_d = instr_word_q;
    load_buf_d   = load_buf_q;
    load_pend_d  = load_pend_q;
    acc_done_d   = acc_done_q;
    bus_error_d  = bus_error_q;
    advance      = 1'b0;

    unique case (state_q)
      FETCH: begin
        // The pending load is handed over in the first FETCH cycle only.
        load_pend_d = 1'b0;
        if (!strobe) begin
          if (instr_address == HALT_ADDR) begin
            state_d = HALTED;
          end else begin
            read_d       = 1'b1;
            address_d    = instr_address;
            byteenable_d = BE_WORD;
          end
        end else if (!waitrequest) begin
          read_d       = 1'b0;
          instr_word_d = readdata;
          state_d      = EXEC;
        end
      end

      EXEC: begin
        if (strobe) begin
          if (!waitrequest) begin
            read_d     = 1'b0;
            write_d    = 1'b0;
            acc_done_d = 1'b1;
            if (read_q) begin
              load_buf_d  = readdata;
              load_pend_d = 1'b1;
            end
            advance = !alu_busy;
          end
        end else if (acc_done_q) begin
          advance = !alu_busy;
        end else if (is_load) begin
          read_d       = 1'b1;
          address_d    = dp_readaddr;
          byteenable_d = dp_byteenable;
        end else if (is_store) begin
          write_d      = 1'b1;
          address_d    = dp_writeaddr;
          writedata_d  = dp_writedata;
          byteenable_d = dp_byteenable;
        end else begin
          acc_done_d = 1'b1;
          advance    = !alu_busy;
        end
        if (advance) begin
          state_d    = FETCH;
          acc_done_d = 1'b0;
        end
      end

      HALTED: begin
        read_d  = 1'b0;
        write_d = 1'b0;
      end

      default: begin
        state_d = HALTED;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase

    if (timeout) begin
      read_d      = 1'b0;
      write_d     = 1'b0;
      bus_error_d = 1'b1;
      acc_done_d  = 1'b0;
      advance     = 1'b0;
      state_d     = HALTED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      instr_word_q <= '0;
      load_buf_q   <= '0;
      load_pend_q  <= 1'b0;
      acc_done_q   <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      instr_word_q <= instr_word_d;
      load_buf_q   <= load_buf_d;
      load_pend_q  <= load_pend_d;
      acc_done_q   <= acc_done_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign address     = address_q;
  assign read        = read_q;
  assign write       = write_q;
  assign writedata   = writedata_q;
  assign byteenable  = byteenable_q;
  assign state       = (state_q == EXEC);
  assign valid_data  = (state_q == FETCH) && load_pend_q;
  assign dp_readdata = valid_data ? load_buf_q : readdata;
  assign instr_word  = instr_word_q;
  assign pc_en       = advance;
  assign active      = (state_q != HALTED);
  assign bus_error   = bus_error_q;
  assign seq_state   = state_q;

endmodule

// File: tb/tb_mips_cpu_bus_sequencer.sv
// Bench for mips_cpu_bus_sequencer: a randomized instruction stream against an
// instruction-level model of the expected bus/handoff events, plus timeout and reset cases.
module tb_mips_cpu_bus_sequencer;
  import mips_cpu_pkg::*;

  localparam int          WAIT_LIMIT = 1024;
  localparam int          EW         = 71;
  localparam logic [31:0] RST_RD     = 32'h0000_1234;
  localparam logic [2:0]  K_FETCH = 3'd0, K_EXEC = 3'd1, K_LOAD = 3'd2,
                          K_STORE = 3'd3, K_PCEN = 3'd4, K_WB = 3'd5;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          kind;   // 0 none, 1 load, 2 store, 3 load+store decoded together
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] ldata;
    logic [3:0]  be;
    int          busy;
    int          fw;
    int          mw;
  } instr_t;

  instr_t prog[64];
  int     n_prog = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_address = 32'h0;
  logic        is_load = 1'b0, is_store = 1'b0, alu_busy = 1'b0;
  logic [31:0] dp_readaddr = 32'h0, dp_writeaddr = 32'h0, dp_writedata = 32'h0;
  logic [3:0]  dp_byteenable = 4'h0;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = RST_RD;
  logic [31:0] address, writedata, dp_readdata, instr_word;
  logic        read, write, state, valid_data, pc_en, active, bus_error;
  logic [3:0]  byteenable;
  seq_state_t  seq_state;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  mips_cpu_bus_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .instr_address (instr_address),
    .is_load       (is_load),
    .is_store      (is_store),
    .alu_busy      (alu_busy),
    .dp_readaddr   (dp_readaddr),
    .dp_writeaddr  (dp_writeaddr),
    .dp_writedata  (dp_writedata),
    .dp_byteenable (dp_byteenable),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .state         (state),
    .valid_data    (valid_data),
    .dp_readdata   (dp_readdata),
    .instr_word    (instr_word),
    .pc_en         (pc_en),
    .active        (active),
    .bus_error     (bus_error),
    .seq_state     (seq_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] ev(input logic [2:0] k, input logic [3:0] be,
                                       input logic [31:0] a, input logic [31:0] d);
    return {k, be, a, d};
  endfunction

  function automatic string kname(input logic [2:0] k);
    case (k)
      K_FETCH: return "fetch_read";
      K_EXEC:  return "exec_entry";
      K_LOAD:  return "load_read";
      K_STORE: return "store_write";
      K_PCEN:  return "pc_en_exec_len";
      K_WB:    return "load_writeback";
      default: return "unknown";
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic observe(input logic [EW-1:0] got);
    logic [EW-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected got=%h exp=none", kname(got[70:68]), got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", kname(exp[70:68]), got, exp);
      end
    end
  endtask

  task automatic set_instr(input int i, input logic [31:0] pc, input logic [31:0] instr,
                           input int kind, input logic [31:0] raddr, input logic [31:0] waddr,
                           input logic [31:0] wdata, input logic [31:0] ldata,
                           input logic [3:0] be, input int busy, input int fw, input int mw);
    prog[i].pc = pc;       prog[i].instr = instr; prog[i].kind = kind;
    prog[i].raddr = raddr; prog[i].waddr = waddr; prog[i].wdata = wdata;
    prog[i].ldata = ldata; prog[i].be = be;       prog[i].busy = busy;
    prog[i].fw = fw;       prog[i].mw = mw;
  endtask

  // Instruction-level reference: each instruction yields a fetch, an EXEC entry showing
  // the fetched word, at most one data access (load wins), the PC pulse carrying the
  // EXEC length, and for loads a writeback in the next FETCH. A fetch address of 0 halts.
  task automatic build_expected();
    int len;
    bit has_mem, has_ld;
    exp_q.delete();
    for (int i = 0; i < n_prog; i++) begin
      if (prog[i].pc == 32'h0) break;
      exp_q.push_back(ev(K_FETCH, BE_WORD, prog[i].pc, 32'h0));
      exp_q.push_back(ev(K_EXEC, 4'h0, 32'h0, prog[i].instr));
      has_ld  = (prog[i].kind == 1) || (prog[i].kind == 3);
      has_mem = (prog[i].kind != 0);
      if (has_ld)
        exp_q.push_back(ev(K_LOAD, prog[i].be, prog[i].raddr, 32'h0));
      else if (has_mem)
        exp_q.push_back(ev(K_STORE, prog[i].be, prog[i].waddr, prog[i].wdata));
      len = has_mem ? 2 + prog[i].mw : 1;
      if (prog[i].busy + 1 > len) len = prog[i].busy + 1;
      exp_q.push_back(ev(K_PCEN, 4'h0, 32'h0, 32'(len)));
      if (has_ld) exp_q.push_back(ev(K_WB, 4'h0, 32'h0, prog[i].ldata));
    end
  endtask

  // ---------------- driver: PC/decoder, ALU and bus slave environment ----------------
  int idx = 0, wcnt = 0, exec_cyc = 0, tgt = 0;
  bit adv = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      idx = 0; wcnt = 0; exec_cyc = 0; adv = 1'b0;
      waitrequest = 1'b0;
      alu_busy    = 1'b0;
      readdata    = RST_RD;
    end else begin
      if (adv) begin
        idx++;
        adv = 1'b0;
      end
      if (idx >= n_prog) idx = n_prog - 1;
      if (state) begin
        alu_busy = (exec_cyc < prog[idx].busy);
        exec_cyc++;
      end else begin
        alu_busy = 1'($urandom_range(0, 1));
        exec_cyc = 0;
      end
      tgt = state ? prog[idx].mw : prog[idx].fw;
      if (read || write) begin
        if (wcnt < tgt) begin
          waitrequest = 1'b1;
          wcnt++;
          readdata = $urandom;
        end else begin
          waitrequest = 1'b0;
          wcnt = 0;
          readdata = state ? prog[idx].ldata : prog[idx].instr;
        end
      end else begin
        waitrequest = 1'($urandom_range(0, 1));
        readdata = $urandom;
      end
    end
    instr_address = prog[idx].pc;
    is_load       = (prog[idx].kind == 1) || (prog[idx].kind == 3);
    is_store      = (prog[idx].kind == 2) || (prog[idx].kind == 3);
    dp_readaddr   = prog[idx].raddr;
    dp_writeaddr  = prog[idx].waddr;
    dp_writedata  = prog[idx].wdata;
    dp_byteenable = prog[idx].be;
    if (reset) begin
      #1;
      if (pc_en) adv = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit          prev_stall = 1'b0, prev_state = 1'b0;
  logic [69:0] prev_bus = '0;
  int          exec_run = 0;

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      prev_stall = 1'b0;
      prev_state = 1'b0;
      exec_run   = 0;
    end else begin
      if (prev_stall && !bus_error) begin
        checks++;
        if ({read, write, address, byteenable, writedata} !== prev_bus) begin
          failures++;
          $display("FAIL bus_hold_during_wait got=%h exp=%h",
                   {read, write, address, byteenable, writedata}, prev_bus);
        end
      end
      prev_stall = (read || write) && waitrequest;
      prev_bus   = {read, write, address, byteenable, writedata};
      if (state && !prev_state) observe(ev(K_EXEC, 4'h0, 32'h0, instr_word));
      if (state) exec_run++;
      if ((read || write) && !waitrequest) begin
        if (read && write) begin
          checks++;
          failures++;
          $display("FAIL dual_strobe got=11 exp=one_of");
        end
        if (read && !state)     observe(ev(K_FETCH, byteenable, address, 32'h0));
        else if (read && state) observe(ev(K_LOAD, byteenable, address, 32'h0));
        else                    observe(ev(K_STORE, byteenable, address, writedata));
      end
      if (pc_en) begin
        observe(ev(K_PCEN, 4'h0, 32'h0, 32'(exec_run)));
        exec_run = 0;
      end
      if (valid_data) observe(ev(K_WB, 4'h0, 32'h0, dp_readdata));
      prev_state = state;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int   guard;
    int   stalls;
    logic strobe_seen;

    // Directed prefix, random body, halt at address 0.
    set_instr(0, 32'hBFC0_0000, 32'h2402_0005, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    set_instr(1, 32'hBFC0_0004, 32'h0000_0820, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 3, 0);
    set_instr(2, 32'hBFC0_0008, 32'h8C22_0004, 1, 32'h0000_1004, 32'h0, 32'h0,
              32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    set_instr(3, 32'hBFC0_000C, 32'hA023_0002, 2, 32'h0, 32'h0000_2002, 32'h0000_AB00,
              32'h0, 4'b0100, 0, 0, 0);
    set_instr(4, 32'hBFC0_0010, 32'h0043_001A, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 5, 0, 0);
    for (int i = 5; i < 45; i++) begin
      set_instr(i, ($urandom | 32'h10) & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 3),
                $urandom, $urandom, $urandom, $urandom, 4'($urandom_range(1, 15)),
                $urandom_range(0, 1) ? $urandom_range(1, 6) : 0,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
    set_instr(45, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    n_prog = 46;
    build_expected();

    repeat (3) @(negedge clk);
    #3;
    chk("rst_read", 32'(read), 32'h0);
    chk("rst_write", 32'(write), 32'h0);
    chk("rst_address", address, 32'h0);
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_byteenable", 32'(byteenable), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_valid_data", 32'(valid_data), 32'h0);
    chk("rst_pc_en", 32'(pc_en), 32'h0);
    chk("rst_instr_word", instr_word, 32'h0);
    chk("rst_active", 32'(active), 32'h1);
    chk("rst_bus_error", 32'(bus_error), 32'h0);
    chk("rst_seq_state", 32'(seq_state), 32'(FETCH));
    chk("rst_dp_readdata_pass", dp_readdata, RST_RD);

    @(negedge clk);
    #4 reset = 1'b1;
    @(negedge clk);
    #3;
    chk("first_fetch_read", 32'(read), 32'h1);
    chk("first_fetch_addr", address, 32'hBFC0_0000);
    chk("first_fetch_be", 32'(byteenable), 32'(BE_WORD));

    guard = 0;
    while (active && guard < 20000) begin
      @(negedge clk);
      #3;
      guard++;
    end
    chk("halt_reached", 32'(active), 32'h0);
    strobe_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      #3;
      if (read || write) strobe_seen = 1'b1;
    end
    chk("halt_no_strobe", 32'(strobe_seen), 32'h0);
    chk("halt_no_bus_error", 32'(bus_error), 32'h0);
    chk("events_all_seen", 32'(exp_q.size()), 32'h0);

    // Fetch stuck in waitrequest: expect a bus error after exactly WAIT_LIMIT stalls.
    reset = 1'b0;
    exp_q.delete();
    set_instr(0, 32'h0000_0100, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 100000, 0);
    n_prog = 1;
    repeat (2) @(negedge clk);
    #4 reset = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      #3;
      guard++;
    end while (!read && guard < 20);
    chk("stuck_fetch_issued", 32'(read), 32'h1);
    stalls = 0;
    guard  = 0;
    while (read && guard < 3000) begin
      if (waitrequest) stalls++;
      @(negedge clk);
      #3;
      guard++;
    end
    chk("timeout_stall_count", 32'(stalls), 32'(WAIT_LIMIT));
    chk("timeout_bus_error", 32'(bus_error), 32'h1);
    chk("timeout_inactive", 32'(active), 32'h0);
    chk("timeout_strobes_low", 32'({read, write}), 32'h0);
    chk("timeout_seq_state", 32'(seq_state), 32'(HALTED));
    reset = 1'b0;
    #1;
    chk("rst_clears_bus_error", 32'(bus_error), 32'h0);
    chk("rst_clears_halt", 32'(active), 32'h1);

    // Reset dropped in the middle of a stalled access.
    @(negedge clk);
    #4 reset = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    chk("midstall_read_high", 32'(read), 32'h1);
    reset = 1'b0;
    #1;
    chk("midstall_rst_read", 32'(read), 32'h0);
    chk("midstall_rst_write", 32'(write), 32'h0);
    chk("midstall_rst_bus_error", 32'(bus_error), 32'h0);
    chk("midstall_rst_state", 32'(seq_state), 32'(FETCH));

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
